// File: rtl/ret_pkg.sv
// Shared types and helpers for the retention lockstep checker.
package ret_pkg;

  typedef enum logic [2:0] {
    ST_RUN         = 3'd0,
    ST_SUSP_WAIT   = 3'd1,
    ST_RESTORE     = 3'd2,
    ST_SUSPENDED   = 3'd3,
    ST_RESUME_WAIT = 3'd4,
    ST_SETTLE      = 3'd5
  } lc_state_e;

  localparam int unsigned SETTLE_W  = 8;
  localparam int unsigned MAX_CH_W  = 64;
  localparam int unsigned MAX_BUS_W = 2048;

  // Extract channel idx of width w from a packed channel bus (caller narrows the result).
  function automatic logic [MAX_CH_W-1:0] ch_slice(input logic [MAX_BUS_W-1:0] bus,
                                                   input int unsigned idx,
                                                   input int unsigned w);
    return MAX_CH_W'(bus >> (idx * w));
  endfunction

endpackage

// File: rtl/ret_first_capture.sv
// Priority-encodes the lowest mismatching channel and latches the first failure.
module ret_first_capture
  import ret_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned CH_W   = 32,
  localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr,
  input  logic [NUM_CH-1:0]      raw,
  input  logic [NUM_CH*CH_W-1:0] gold,
  input  logic [NUM_CH*CH_W-1:0] test,
  output logic                   first_valid,
  output logic [IDX_W-1:0]       first_ch,
  output logic [CH_W-1:0]        first_gold,
  output logic [CH_W-1:0]        first_test
);

  logic [IDX_W-1:0] sel;
  logic [CH_W-1:0]  sel_gold;
  logic [CH_W-1:0]  sel_test;

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    sel = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (raw[k]) sel = IDX_W'(k);
    end
  end

  assign sel_gold = CH_W'(ch_slice(MAX_BUS_W'(gold), 32'(sel), CH_W));
  assign sel_test = CH_W'(ch_slice(MAX_BUS_W'(test), 32'(sel), CH_W));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      first_valid <= 1'b0;
      first_ch    <= '0;
      first_gold  <= '0;
      first_test  <= '0;
    end else if (clr) begin
      first_valid <= 1'b0;
      first_ch    <= '0;
      first_gold  <= '0;
      first_test  <= '0;
    end else if (|raw && !first_valid) begin
      first_valid <= 1'b1;
      first_ch    <= sel;
      first_gold  <= sel_gold;
      first_test  <= sel_test;
    end
  end

endmodule

// File: rtl/ret_lockstep_checker.sv
// Lockstep compare of golden vs partial-retention design with suspend/resume sequencing.
module ret_lockstep_checker
  import ret_pkg::*;
#(
  parameter  int unsigned NUM_CH     = 4,
  parameter  int unsigned CH_W       = 32,
  parameter  int unsigned CNT_W      = 16,
  parameter  int unsigned SETTLE_CYC = 2,
  localparam int unsigned IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_CH*CH_W-1:0] gold_i,
  input  logic [NUM_CH*CH_W-1:0] test_i,
  input  logic [NUM_CH-1:0]      ch_en_i,
  input  logic                   susp_req_i,
  input  logic                   resume_req_i,
  input  logic                   suspended_i,
  input  logic                   clr_i,
  output logic                   pr_restore_o,
  output logic                   check_active_o,
  output logic                   mismatch_o,
  output logic [NUM_CH-1:0]      mismatch_ch_o,
  output logic                   first_valid_o,
  output logic [IDX_W-1:0]       first_ch_o,
  output logic [CH_W-1:0]        first_gold_o,
  output logic [CH_W-1:0]        first_test_o,
  output logic [CNT_W-1:0]       err_cnt_o,
  output logic                   proto_err_o,
  output logic [2:0]             state_o
);

  lc_state_e           state_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                susp_q;
  logic                rise;
  logic                fall;
  logic                proto_hit;
  logic [NUM_CH-1:0]   raw;

  assign rise    = suspended_i & ~susp_q;
  assign fall    = ~suspended_i & susp_q;
  assign state_o = state_q;

  // Gated by reset so every output reads 0 while reset is held.
  assign check_active_o = ~rst_i &
                          ((state_q == ST_RUN) | ((state_q == ST_SUSP_WAIT) & ~suspended_i));

  always_comb begin
    raw = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      raw[k] = ch_en_i[k] & check_active_o &
               (CH_W'(ch_slice(MAX_BUS_W'(gold_i), k, CH_W)) !=
                CH_W'(ch_slice(MAX_BUS_W'(test_i), k, CH_W)));
    end
  end

  // A rise in RUN together with susp_req is a legal fast suspend.
  always_comb begin
    proto_hit = 1'b0;
    if (rise && (state_q != ST_SUSP_WAIT) && !((state_q == ST_RUN) && susp_req_i))
      proto_hit = 1'b1;
    if (resume_req_i && ((state_q == ST_RUN) || (state_q == ST_SUSP_WAIT)))
      proto_hit = 1'b1;
    if (susp_req_i && ((state_q == ST_SUSPENDED) || (state_q == ST_RESUME_WAIT)))
      proto_hit = 1'b1;
    if (fall && (state_q == ST_SUSPENDED) && !resume_req_i)
      proto_hit = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      settle_q     <= '0;
      pr_restore_o <= 1'b0;
    end else begin
      pr_restore_o <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (rise) begin
            state_q      <= ST_RESTORE;
            pr_restore_o <= 1'b1;
          end else if (susp_req_i) begin
            state_q <= ST_SUSP_WAIT;
          end
        end
        ST_SUSP_WAIT: begin
          if (suspended_i) begin
            state_q      <= ST_RESTORE;
            pr_restore_o <= 1'b1;
          end
        end
        ST_RESTORE: state_q <= ST_SUSPENDED;
        ST_SUSPENDED: begin
          if (resume_req_i) begin
            state_q <= ST_RESUME_WAIT;
          end else if (fall) begin
            state_q  <= ST_SETTLE;
            settle_q <= '0;
          end
        end
        ST_RESUME_WAIT: begin
          if (!suspended_i) begin
            state_q  <= ST_SETTLE;
            settle_q <= '0;
          end
        end
        ST_SETTLE: begin
          if (rise) begin
            state_q      <= ST_RESTORE;
            pr_restore_o <= 1'b1;
          end else if (settle_q == SETTLE_W'(SETTLE_CYC - 1)) begin
            state_q <= ST_RUN;
          end else begin
            settle_q <= settle_q + SETTLE_W'(1);
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Compare results, saturating error count and sticky protocol flag; clear wins over new data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      susp_q        <= 1'b0;
      mismatch_o    <= 1'b0;
      mismatch_ch_o <= '0;
      err_cnt_o     <= '0;
      proto_err_o   <= 1'b0;
    end else begin
      susp_q        <= suspended_i;
      mismatch_o    <= |raw;
      mismatch_ch_o <= raw;
      if (clr_i) begin
        err_cnt_o   <= '0;
        proto_err_o <= 1'b0;
      end else begin
        if (|raw && (err_cnt_o != {CNT_W{1'b1}})) err_cnt_o <= err_cnt_o + CNT_W'(1);
        if (proto_hit) proto_err_o <= 1'b1;
      end
    end
  end

  ret_first_capture #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_first (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr         (clr_i),
    .raw         (raw),
    .gold        (gold_i),
    .test        (test_i),
    .first_valid (first_valid_o),
    .first_ch    (first_ch_o),
    .first_gold  (first_gold_o),
    .first_test  (first_test_o)
  );

endmodule
